// File: rtl/reg_bank_read.sv
// -----------------------------------------------------------------------------
// reg_bank_read
//
// General-purpose register bank for the multicycle MIPS datapath.
// Holds 2**ADDR_W registers of DATA_W bits. Register 0 always reads as zero.
// Register SP_INDEX ($sp) resets to SP_RESET. The two read ports are
// registered and feed the A/B operand registers ahead of the ALU.
//
// Configuration macro:
//   REGBANK_BYPASS_EN  When defined, a read port whose index matches the
//                      register being written on the same edge captures the
//                      incoming write data. Each port is bypassed on its own.
//                      When undefined, a read on that edge captures the old
//                      contents (read-before-write).
//
// Ports:
//   clk           in   system clock; all state updates on the rising edge
//   reset         in   asynchronous, active-high reset
//   RegWrite      in   write enable for the write port
//   WriteRegFio   in   destination register index
//   WriteDataFio  in   data from the write-data mux
//   ReadReg1Fio   in   read port 1 index (rs)
//   ReadReg2Fio   in   read port 2 index (rt)
//   LoadAB        in   capture enable for both read output registers
//   ReadData1Fio  out  registered read port 1 (A)
//   ReadData2Fio  out  registered read port 2 (B)
//
// Timing: there is no valid/ready handshake. A write takes effect on the
// rising edge where RegWrite=1. A read index presented with LoadAB=1 is
// captured on that edge, so its value appears one cycle later. With LoadAB=0
// both outputs hold their value.
// -----------------------------------------------------------------------------
module reg_bank_read #(
   parameter int              DATA_W   = 32,
   parameter int              ADDR_W   = 5,
   parameter int              SP_INDEX = 29,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteRegFio,
   input  logic [DATA_W-1:0] WriteDataFio,
   input  logic [ADDR_W-1:0] ReadReg1Fio,
   input  logic [ADDR_W-1:0] ReadReg2Fio,
   input  logic              LoadAB,
   output logic [DATA_W-1:0] ReadData1Fio,
   output logic [DATA_W-1:0] ReadData2Fio
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [0:NREG-1];
   logic [DATA_W-1:0] rd1_val;
   logic [DATA_W-1:0] rd2_val;
   logic              wr_en;

   // Writes to index 0 are dropped so register 0 stays at its reset value of 0.
   assign wr_en = RegWrite && (WriteRegFio != '0);

   // Storage. Reset has priority over a write on the same edge, so a write
   // that overlaps reset is discarded completely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
         end
      end else if (wr_en) begin
         regs[WriteRegFio] <= WriteDataFio;
      end
   end

   // Values to capture into the read registers. The array read gives the
   // pre-edge contents. Forcing index 0 to zero is redundant with storage,
   // but it keeps the read side correct on its own.
   always_comb begin
      rd1_val = regs[ReadReg1Fio];
      rd2_val = regs[ReadReg2Fio];
      if (ReadReg1Fio == '0) rd1_val = '0;
      if (ReadReg2Fio == '0) rd2_val = '0;
`ifdef REGBANK_BYPASS_EN
      if (wr_en && (WriteRegFio == ReadReg1Fio)) rd1_val = WriteDataFio;
      if (wr_en && (WriteRegFio == ReadReg2Fio)) rd2_val = WriteDataFio;
`endif
   end

   // Registered read ports (A and B operand registers).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ReadData1Fio <= '0;
         ReadData2Fio <= '0;
      end else if (LoadAB) begin
         ReadData1Fio <= rd1_val;
         ReadData2Fio <= rd2_val;
      end
   end

endmodule

// File: tb/tb_reg_bank_read.sv
module tb_reg_bank_read;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        RegWrite = 1'b0;
   logic [4:0]  WriteRegFio = '0;
   logic [31:0] WriteDataFio = '0;
   logic [4:0]  ReadReg1Fio = '0;
   logic [4:0]  ReadReg2Fio = '0;
   logic        LoadAB = 1'b0;
   logic [31:0] ReadData1Fio;
   logic [31:0] ReadData2Fio;

   int tests_run = 0;
   int tests_failed = 0;

`ifdef REGBANK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   reg_bank_read dut (
      .clk          (clk),
      .reset        (reset),
      .RegWrite     (RegWrite),
      .WriteRegFio  (WriteRegFio),
      .WriteDataFio (WriteDataFio),
      .ReadReg1Fio  (ReadReg1Fio),
      .ReadReg2Fio  (ReadReg2Fio),
      .LoadAB       (LoadAB),
      .ReadData1Fio (ReadData1Fio),
      .ReadData2Fio (ReadData2Fio)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_regs [32];
   logic [31:0] m_a;
   logic [31:0] m_b;

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (BYPASS && RegWrite && WriteRegFio != 5'd0 && WriteRegFio == idx)
         return WriteDataFio;
      return m_regs[idx];
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_regs[29] = 32'd227;
         m_a = 32'd0;
         m_b = 32'd0;
      end else begin
         // Reads see the registers as they were before this edge.
         if (LoadAB) begin
            m_a = model_read(ReadReg1Fio);
            m_b = model_read(ReadReg2Fio);
         end
         if (RegWrite && WriteRegFio != 5'd0) m_regs[WriteRegFio] = WriteDataFio;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge once the model is initialised.
   bit model_live = 1'b0;
   always @(negedge clk) begin
      if (model_live) begin
         check("model_A", ReadData1Fio, m_a);
         check("model_B", ReadData2Fio, m_b);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic ld, input logic [4:0] r1, input logic [4:0] r2);
      RegWrite     = we;
      WriteRegFio  = wr;
      WriteDataFio = wd;
      LoadAB       = ld;
      ReadReg1Fio  = r1;
      ReadReg2Fio  = r2;
   endtask

   // Inputs change just after the falling edge. This task advances one rising
   // edge and returns on the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      model_live = 1'b1;
      check("reset_A_held", ReadData1Fio, 32'd0);
      check("reset_B_held", ReadData2Fio, 32'd0);
      step();
      reset = 1'b0;

      // Initial reset values.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd5); step();
      check("rst_sp", ReadData1Fio, 32'd227);
      check("rst_r5", ReadData2Fio, 32'd0);
      check("model_pin_sp", m_a, 32'd227);

      // Make the outputs nonzero, then pulse reset between edges.
      drive(1'b1, 5'd5, 32'h0000_0007, 1'b0, 5'd0, 5'd0); step();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd29); step();
      check("pre_pulse_A", ReadData1Fio, 32'h7);
      idle();
      #2 reset = 1'b1;
      #1;
      check("async_A", ReadData1Fio, 32'd0);
      check("async_B", ReadData2Fio, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd5); step();
      check("pulse_sp", ReadData1Fio, 32'd227);
      check("pulse_r5", ReadData2Fio, 32'd0);

      // Write then read on both ports.
      drive(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0); step();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8); step();
      check("wr8_A", ReadData1Fio, 32'hDEAD_BEEF);
      check("wr8_B", ReadData2Fio, 32'hDEAD_BEEF);

      // Register zero ignores writes, including one on the same edge as the read.
      drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd8); step();
      check("r0_same_edge", ReadData1Fio, 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0); step();
      check("r0_A", ReadData1Fio, 32'd0);
      check("r0_B", ReadData2Fio, 32'd0);

      // Same-edge write/read hazard on register 3.
      drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0); step();
      drive(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 5'd8); step();
      check("hazard_A", ReadData1Fio, BYPASS ? 32'h22 : 32'h11);
      check("hazard_B_other", ReadData2Fio, 32'hDEAD_BEEF);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3); step();
      check("hazard_after_A", ReadData1Fio, 32'h22);
      check("hazard_after_B", ReadData2Fio, 32'h22);

      // Port 2 bypass alone, with port 1 on a different register.
      drive(1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 5'd8, 5'd9); step();
      check("byp2_A", ReadData1Fio, 32'hDEAD_BEEF);
      check("byp2_B", ReadData2Fio, BYPASS ? 32'hCAFE_0009 : 32'd0);

      // Hold while LoadAB is low.
      drive(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0); step();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0); step();
      check("hold_load", ReadData1Fio, 32'hA5A5_A5A5);
      drive(1'b1, 5'd4, 32'd0, 1'b0, 5'd4, 5'd4); step();
      check("hold_1", ReadData1Fio, 32'hA5A5_A5A5);
      idle(); step(); step();
      check("hold_3", ReadData1Fio, 32'hA5A5_A5A5);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0); step();
      check("hold_reload", ReadData1Fio, 32'd0);

      // Reset asserted in the same cycle as a write to $sp.
      drive(1'b1, 5'd29, 32'h55, 1'b0, 5'd0, 5'd0);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd8); step();
      check("midwr_sp", ReadData1Fio, 32'd227);
      check("midwr_r8", ReadData2Fio, 32'd0);

      // Short walk through several registers with distinct data patterns.
      for (int i = 1; i < 8; i++) begin
         drive(1'b1, 5'(i + 16), 32'h0101_0101 * i, 1'b0, 5'd0, 5'd0); step();
      end
      for (int i = 1; i < 8; i++) begin
         drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 16), 5'(24 - i)); step();
         check("walk_A", ReadData1Fio, 32'h0101_0101 * i);
         check("walk_B", ReadData2Fio, 32'h0101_0101 * (8 - i));
      end

      idle(); step();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      tests_run++;
      tests_failed++;
      $display("FAIL timeout: run did not finish, got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
